// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core with load-use hazard
// detection. Decoded control, operands and register specifiers are captured
// from the decode stage on every rising edge and presented to the execute
// stage one cycle later. ex_alu_op and ex_funct feed the ALU control decoder.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               branch taken: the instruction entering EX is killed
//   hold                global freeze: every register keeps its value
//   id_*                decoded instruction fields from the decode stage
//   ex_*                registered copies of id_* presented to execute
//   ex_valid            1 = EX holds a real instruction, 0 = bubble
//   stall               combinational; freezes the PC and the IF/ID register
//   stall_count         saturating count of load-use bubbles inserted
// -----------------------------------------------------------------------------
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              hold,
   input  logic [1:0]        id_alu_op,
   input  logic [5:0]        id_funct,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic              id_branch,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   output logic [1:0]        ex_alu_op,
   output logic [5:0]        ex_funct,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_reg_write,
   output logic              ex_branch,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic              ex_valid,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);

   logic haz;
   logic load_bubble;
   logic cnt_sat;

   // A load in EX whose destination is read by the instruction in ID.
   // $zero is never a real dependency, and a bubble has ex_mem_read=0 so it
   // can never retrigger the hazard on the following cycle.
   always_comb begin
      haz = ex_valid & ex_mem_read & (ex_rt != 5'd0)
            & ((ex_rt == id_rs) | (ex_rt == id_rt));
   end

   // hold deliberately does not mask stall: the front end must stay frozen
   // for as long as the load-use condition is pending.
   assign stall   = haz & ~flush & ~reset;
   assign cnt_sat = &stall_count;

   // flush and a hazard both produce a bubble; only the hazard path counts it.
   assign load_bubble = flush | haz;

   // Pipeline register update. Priority: reset, flush, hold, hazard, load.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_alu_op     <= 2'b00;
         ex_funct      <= 6'b000000;
         ex_reg_dst    <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_pc4        <= '0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_rd         <= 5'd0;
         ex_valid      <= 1'b0;
         stall_count   <= '0;
      end else if (flush || (!hold && load_bubble)) begin
         ex_alu_op     <= 2'b00;
         ex_funct      <= 6'b000000;
         ex_reg_dst    <= 1'b0;
         ex_alu_src    <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         ex_mem_to_reg <= 1'b0;
         ex_reg_write  <= 1'b0;
         ex_branch     <= 1'b0;
         ex_rd1        <= '0;
         ex_rd2        <= '0;
         ex_imm        <= '0;
         ex_pc4        <= '0;
         ex_rs         <= 5'd0;
         ex_rt         <= 5'd0;
         ex_rd         <= 5'd0;
         ex_valid      <= 1'b0;
         // Only a genuine load-use bubble is counted, never a flush.
         if (!flush && !cnt_sat) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else if (!hold) begin
         ex_alu_op     <= id_alu_op;
         ex_funct      <= id_funct;
         ex_reg_dst    <= id_reg_dst;
         ex_alu_src    <= id_alu_src;
         ex_mem_read   <= id_mem_read;
         ex_mem_write  <= id_mem_write;
         ex_mem_to_reg <= id_mem_to_reg;
         ex_reg_write  <= id_reg_write;
         ex_branch     <= id_branch;
         ex_rd1        <= id_rd1;
         ex_rd2        <= id_rd2;
         ex_imm        <= id_imm;
         ex_pc4        <= id_pc4;
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_rd         <= id_rd;
         ex_valid      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. A driver issues directed and random
// decode-stage traffic; for every cycle a behavioural model pushes the expected
// stall value and the expected post-edge EX contents into queues, and a
// monitor process pops and compares them against the DUT.
// The counter width is reduced so that saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;

   typedef struct packed {
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic        reg_dst;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        reg_write;
      logic        branch;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } instr_t;

   typedef struct packed {
      instr_t           ex;
      logic             valid;
      logic [CNT_W-1:0] cnt;
   } state_t;

   logic clk = 1'b0;
   logic reset_r = 1'b1;
   logic flush_r = 1'b0;
   logic hold_r = 1'b0;
   instr_t cur = '0;

   logic [1:0]        ex_alu_op;
   logic [5:0]        ex_funct;
   logic              ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write;
   logic              ex_mem_to_reg, ex_reg_write, ex_branch;
   logic [DATA_W-1:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
   logic [4:0]        ex_rs, ex_rt, ex_rd;
   logic              ex_valid, stall;
   logic [CNT_W-1:0]  stall_count;
   instr_t            dut_ex;

   int passCount = 0;
   int checkCount = 0;

   logic   stall_q[$];
   state_t state_q[$];
   state_t mdl = '0;

   always #5 clk = ~clk;

   id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset_r), .flush(flush_r), .hold(hold_r),
      .id_alu_op(cur.alu_op), .id_funct(cur.funct),
      .id_reg_dst(cur.reg_dst), .id_alu_src(cur.alu_src),
      .id_mem_read(cur.mem_read), .id_mem_write(cur.mem_write),
      .id_mem_to_reg(cur.mem_to_reg), .id_reg_write(cur.reg_write),
      .id_branch(cur.branch),
      .id_rd1(cur.rd1), .id_rd2(cur.rd2), .id_imm(cur.imm), .id_pc4(cur.pc4),
      .id_rs(cur.rs), .id_rt(cur.rt), .id_rd(cur.rd),
      .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
      .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
      .ex_branch(ex_branch),
      .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_valid(ex_valid), .stall(stall), .stall_count(stall_count)
   );

   assign dut_ex = {ex_alu_op, ex_funct, ex_reg_dst, ex_alu_src, ex_mem_read,
                    ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch,
                    ex_rd1, ex_rd2, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd};

   // Single comparison point; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [199:0] act,
                              input logic [199:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h at t=%0t",
                    name, act, exp, $time);
   endtask

   // Control word order: reg_dst alu_src mem_read mem_write mem_to_reg
   // reg_write branch.
   function automatic instr_t mk(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [6:0] ctl, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b);
      instr_t r;
      r.alu_op = op;  r.funct = fn;
      {r.reg_dst, r.alu_src, r.mem_read, r.mem_write,
       r.mem_to_reg, r.reg_write, r.branch} = ctl;
      r.rd1 = a;  r.rd2 = b;
      r.imm = 32'hFFFF_FFF0;  r.pc4 = 32'h0000_0404;
      r.rs = rs;  r.rt = rt;  r.rd = rd;
      return r;
   endfunction

   function automatic instr_t randInstr();
      instr_t r;
      r.alu_op = 2'($urandom_range(0, 2));
      r.funct = 6'($urandom);
      {r.reg_dst, r.alu_src, r.mem_write, r.mem_to_reg, r.reg_write, r.branch}
         = 6'($urandom);
      r.mem_read = ($urandom_range(0, 1) == 1);
      r.rd1 = $urandom;  r.rd2 = $urandom;
      r.imm = $urandom;  r.pc4 = $urandom;
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.rd = 5'($urandom);
      return r;
   endfunction

   // Drives one cycle of decode-stage inputs and records what the pipeline
   // register is expected to do with them.
   task automatic applyStimulus(input instr_t ins, input logic rst,
                                input logic fl, input logic hd);
      logic dep;
      @(posedge clk);
      #2;
      cur = ins;  reset_r = rst;  flush_r = fl;  hold_r = hd;
      dep = mdl.valid && mdl.ex.mem_read && (mdl.ex.rt != 0)
            && (mdl.ex.rt == ins.rs || mdl.ex.rt == ins.rt);
      stall_q.push_back(dep && !fl && !rst);
      if (rst) mdl = '0;
      else if (fl) begin
         mdl.ex = '0;  mdl.valid = 1'b0;
      end else if (hd) begin
         mdl = mdl;
      end else if (dep) begin
         mdl.ex = '0;  mdl.valid = 1'b0;
         if (int'(mdl.cnt) < (1 << CNT_W) - 1) mdl.cnt = mdl.cnt + 1'b1;
      end else begin
         mdl.ex = ins;  mdl.valid = 1'b1;
      end
      state_q.push_back(mdl);
   endtask

   // Monitor: stall is checked mid-cycle, registered state just after the edge.
   initial begin
      state_t e;
      forever begin
         @(negedge clk);
         if (stall_q.size() > 0) checkOutput("stall", stall, stall_q.pop_front());
         @(posedge clk);
         #1;
         if (state_q.size() > 0) begin
            e = state_q.pop_front();
            checkOutput("ex_fields", dut_ex, e.ex);
            checkOutput("ex_valid", ex_valid, e.valid);
            checkOutput("stall_count", stall_count, e.cnt);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      instr_t lw8, add8, addr, idle;
      idle = '0;
      lw8  = mk(2'b00, 6'h00, 7'b0110110, 5'd9, 5'd8, 5'd0, 32'd100, 32'd0);
      add8 = mk(2'b10, 6'b100000, 7'b1000010, 5'd8, 5'd2, 5'd3, 32'd1, 32'd2);
      addr = mk(2'b10, 6'b100000, 7'b1000010, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);

      // Reset, then plain pass-through of an R-type add.
      applyStimulus(addr, 1'b1, 1'b0, 1'b0);
      applyStimulus(addr, 1'b1, 1'b0, 1'b0);
      applyStimulus(addr, 1'b0, 1'b0, 1'b0);

      // Load-use: one bubble, then the dependent add enters EX.
      applyStimulus(lw8, 1'b0, 1'b0, 1'b0);
      applyStimulus(add8, 1'b0, 1'b0, 1'b0);
      applyStimulus(add8, 1'b0, 1'b0, 1'b0);

      // Load into $zero and a store never stall.
      applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd9, 5'd0, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(mk(2'b10, 6'h20, 7'b1000010, 5'd0, 5'd0, 5'd4, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(mk(2'b00, 6'h00, 7'b0101000, 5'd9, 5'd8, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(add8, 1'b0, 1'b0, 1'b0);

      // Flush wins over a pending hazard.
      applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd9, 5'd4, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(mk(2'b10, 6'h20, 7'b1000010, 5'd4, 5'd2, 5'd5, 0, 0), 1'b0, 1'b1, 1'b0);

      // Hold for three cycles while a hazard is pending, then release.
      applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd9, 5'd4, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(mk(2'b10, 6'h20, 7'b1000010, 5'd4, 5'd2, 5'd5, 0, 0), 1'b0, 1'b0, 1'b1);
      repeat (2) applyStimulus(mk(2'b10, 6'h20, 7'b1000010, 5'd4, 5'd2, 5'd5, 0, 0), 1'b0, 1'b0, 1'b0);

      // Back-to-back dependent loads.
      applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd0, 5'd1, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      repeat (2) applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd1, 5'd2, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);

      // Reset arriving while a stall is pending.
      applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd9, 5'd6, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(mk(2'b10, 6'h20, 7'b1000010, 5'd6, 5'd2, 5'd5, 0, 0), 1'b1, 1'b0, 1'b0);

      // Saturation: a self-dependent load stream forces a bubble every
      // second cycle, 300 times, beyond the 8-bit counter limit.
      repeat (600) applyStimulus(mk(2'b00, 6'h00, 7'b0110110, 5'd5, 5'd5, 5'd0, 0, 0), 1'b0, 1'b0, 1'b0);
      applyStimulus(idle, 1'b0, 1'b0, 1'b0);
      checkOutput("sat_count", stall_count, {CNT_W{1'b1}});

      // Randomized traffic with occasional flush, hold and reset.
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(randInstr(), ($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0));
      end
      applyStimulus(idle, 1'b1, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #3;
      checkOutput("queues_drained", stall_q.size() + state_q.size(), 0);
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded control, operands and register specifiers from the decode stage every cycle, and presents them to the execute stage.
- Its ex_alu_op and ex_funct outputs drive the ALU control decoder directly.
- Inserts a one-cycle bubble on load-use hazards, honours branch flush and global hold, and counts hazard bubbles for performance analysis.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  branch taken; kill the instruction entering EX.
- hold  input  1  global freeze (memory wait); all state holds.
- id_alu_op  input  2  ALUOp from main control (00 lw/sw, 01 beq, 10 R-type).
- id_funct  input  6  instruction[5:0].
- id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch  input  1 each  decoded control bits.
- id_rd1, id_rd2  input  DATA_W  register file read data.
- id_imm  input  DATA_W  sign-extended immediate.
- id_pc4  input  DATA_W  PC+4 of the decoding instruction.
- id_rs, id_rt, id_rd  input  5 each  register specifiers.
- ex_alu_op  output  2  registered; feeds the ALU control decoder.
- ex_funct  output  6  registered; feeds the ALU control decoder.
- ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_branch  output  1 each  registered control bits.
- ex_rd1, ex_rd2, ex_imm, ex_pc4  output  DATA_W  registered data.
- ex_rs, ex_rt, ex_rd  output  5 each  registered specifiers.
- ex_valid  output  1  1 = EX holds a real instruction; 0 = bubble.
- stall  output  1  combinational; holds the PC and the IF/ID register.
- stall_count  output  CNT_W  hazard bubbles inserted, saturating.

Behaviour:
- Reset state:
  - All ex_* outputs are 0, including ex_alu_op=00 and ex_funct=000000.
  - ex_valid=0 and stall_count=0.
  - reset takes priority over every other input.
- Hazard detection (combinational, from current registers):
  - haz = ex_valid & ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt)).
  - stall = haz & ~flush & ~reset.
  - hold does not mask stall.
- Per-edge update priority:
  - reset.
  - flush: load a bubble; ex_valid=0.
  - hold: every register, including stall_count, keeps its value.
  - haz: load a bubble; ex_valid=0; stall_count += 1 unless already all ones.
  - otherwise: load all id_* fields; ex_valid=1.
- Bubble content:
  - Every control output is 0, including alu_op=00 and funct=0.
  - Data and specifier outputs are 0.
  - A bubble therefore cannot write a register or memory, and cannot retrigger haz (ex_mem_read=0).
- Latency:
  - 1 cycle from id_* to ex_*; no combinational path from id_* to ex_*.
  - stall is the only combinational output.
- Load-use sequence:
  - Cycle N: lw in EX, dependent in ID; stall=1.
  - Edge N+1: bubble enters EX; IF/ID holds the dependent.
  - Cycle N+1: stall=0.
  - Edge N+2: the dependent enters EX.
  - Exactly one bubble per load-use pair.
- Boundary conditions:
  - ex_rt=0 never stalls, since $zero is never a real dependency.
  - flush and haz together: flush wins; stall=0; stall_count is not incremented.
  - hold and haz together: state frozen and stall_count unchanged; stall stays 1 while the condition persists.
  - Counter saturation: at all ones, stall_count stays there and does not wrap.
  - Reset mid-stall: all registers are cleared on that edge and stall drops combinationally while reset=1.
  - Back-to-back lw with dependence (lw $1; lw $2,0($1)): one bubble, identical to the ALU-consumer case.

Test Plan:
- Pass-through: R-type add (alu_op=10, funct=100000, rd1=5, rd2=7, rd=3, reg_write=1) in ID, no hazard -> next edge ex_alu_op=10, ex_funct=100000, ex_rd1=5, ex_rd2=7, ex_rd=3, ex_valid=1, stall=0.
- Load-use: lw with rt=8 in EX, then ID presents add with rs=8 -> stall=1 for one cycle; next edge ex_valid=0, ex_alu_op=00, ex_reg_write=0, stall_count=1; following edge the add is in EX with ex_valid=1.
- Zero-register and non-load cases:
  - lw with rt=0, ID rs=0 -> stall=0, no bubble.
  - sw (mem_read=0) with rt=8, ID rs=8 -> stall=0.
- Flush priority: lw rt=4 in EX, ID rs=4, flush=1 -> stall=0; next edge bubble loaded, stall_count unchanged.
- Hold: hold=1 for 3 cycles while a load-use hazard is pending -> ex_* and stall_count frozen, stall=1 throughout; after release, one bubble inserted and stall_count increments by exactly 1.
- Saturation and reset:
  - Force 65536 hazards with CNT_W=16 -> stall_count stops at 0xFFFF.
  - reset=1 mid-stall -> next edge all outputs 0 and stall=0 during reset.
